// File: rtl/yutorina_sfr_arbiter_pkg.sv
`default_nettype none
// ==== yutorina_sfr_arbiter_pkg : shared encodings, bus types and strobe levels (Rev 1.0) ====
package yutorina_sfr_arbiter_pkg;

  localparam int SFR_ADDR_W  = 3;
  localparam int WORD_DATA_W = 32;
  localparam int SFR_NUM     = 6;

  typedef logic [SFR_ADDR_W-1:0]  sfr_addr_bus_t;
  typedef logic [WORD_DATA_W-1:0] word_data_bus_t;

  // Write strobes are active-low throughout the SFR path.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    SFR_ARB_IDLE   = 2'd0,
    SFR_ARB_ACCESS = 2'd1,
    SFR_ARB_ACK    = 2'd2
  } sfr_arb_state_e;

  localparam logic SFR_ARB_M0 = 1'b0;
  localparam logic SFR_ARB_M1 = 1'b1;

  function automatic logic [1:0] owner_mask(input logic owned, input logic owner);
    if (!owned)
      return 2'b11;
    return (owner == SFR_ARB_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/yutorina_sfr_arbiter_rr_arb2.sv
`default_nettype none
// ==== yutorina_rr_arb2 : combinational two-way round-robin pick with request mask (Rev 1.0) ====
module yutorina_rr_arb2
  import yutorina_sfr_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic       valid,
  output logic       grant
);

  logic [1:0] eff;

  always_comb begin
    eff   = req & mask;
    valid = |eff;
    grant = SFR_ARB_M0;
    // On a tie the master that was not served last wins.
    if (eff == 2'b11)
      grant = ~last;
    else if (eff[1])
      grant = SFR_ARB_M1;
  end

endmodule
`default_nettype wire

// File: rtl/yutorina_sfr_arbiter.sv
`default_nettype none
// ==== yutorina_sfr_arbiter : round-robin arbiter and IDLE/ACCESS/ACK sequencer for the SFR file (Rev 1.0) ====
// ==== Optional grant locking is enabled by defining YUTORINA_SFR_ARB_LOCK_EN ====
module yutorina_sfr_arbiter
  import yutorina_sfr_arbiter_pkg::*;
#(
  parameter int ADDR_W = SFR_ADDR_W,
  parameter int DATA_W = WORD_DATA_W,
  parameter int NUM    = SFR_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we_,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  input  logic              m0_lock,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_we_,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  input  logic              m1_lock,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic [ADDR_W-1:0] sfr_rd_addr,
  input  logic [DATA_W-1:0] sfr_rd_data,
  output logic              sfr_we_,
  output logic [ADDR_W-1:0] sfr_wr_addr,
  output logic [DATA_W-1:0] sfr_wr_data,
  output logic              busy
);

  localparam logic [ADDR_W:0] LIMIT = NUM[ADDR_W:0];

  sfr_arb_state_e    state;
  logic              last;
  logic              cmd_master;
  logic [1:0]        mask;
  logic              win_valid;
  logic              win;
  logic              win_we_;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_legal;
  logic              cmd_illegal;

`ifdef YUTORINA_SFR_ARB_LOCK_EN
  logic owned;
  logic owner;
  logic win_lock;

  assign mask     = owner_mask(owned, owner);
  assign win_lock = (win == SFR_ARB_M1) ? m1_lock : m0_lock;
`else
  // Lock inputs only feed a no-op term here; arbitration stays pure round-robin.
  assign mask = 2'b11 | {m1_lock, m0_lock};
`endif

  yutorina_rr_arb2 u_rr (
    .req   ({m1_req, m0_req}),
    .last  (last),
    .mask  (mask),
    .valid (win_valid),
    .grant (win)
  );

  always_comb begin
    win_we_  = m0_we_;
    win_addr = m0_addr;
    win_data = m0_wr_data;
    if (win == SFR_ARB_M1) begin
      win_we_  = m1_we_;
      win_addr = m1_addr;
      win_data = m1_wr_data;
    end
  end

  // sfr_rd_addr doubles as the latched command address.
  assign win_legal   = ({1'b0, win_addr} < LIMIT);
  assign cmd_illegal = ({1'b0, sfr_rd_addr} >= LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SFR_ARB_IDLE;
      last        <= SFR_ARB_M1;
      cmd_master  <= SFR_ARB_M0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
      m0_rd_data  <= '0;
      m1_rd_data  <= '0;
      sfr_we_     <= DISABLE_;
      sfr_rd_addr <= '0;
      sfr_wr_addr <= '0;
      sfr_wr_data <= '0;
      busy        <= 1'b0;
`ifdef YUTORINA_SFR_ARB_LOCK_EN
      owned       <= 1'b0;
      owner       <= SFR_ARB_M0;
`endif
    end else begin
      case (state)
        SFR_ARB_IDLE: begin
          if (win_valid) begin
            state       <= SFR_ARB_ACCESS;
            busy        <= 1'b1;
            cmd_master  <= win;
            sfr_rd_addr <= win_addr;
            sfr_wr_addr <= win_addr;
            sfr_wr_data <= win_data;
            sfr_we_     <= (win_we_ == ENABLE_ && win_legal) ? ENABLE_ : DISABLE_;
`ifdef YUTORINA_SFR_ARB_LOCK_EN
            owned       <= win_lock;
            owner       <= win;
`endif
          end
        end
        SFR_ARB_ACCESS: begin
          // Read data is sampled in the same edge that commits a write: pre-write value.
          state   <= SFR_ARB_ACK;
          sfr_we_ <= DISABLE_;
          last    <= cmd_master;
          if (cmd_master == SFR_ARB_M1) begin
            m1_ack     <= 1'b1;
            m1_err     <= cmd_illegal;
            m1_rd_data <= cmd_illegal ? '0 : sfr_rd_data;
          end else begin
            m0_ack     <= 1'b1;
            m0_err     <= cmd_illegal;
            m0_rd_data <= cmd_illegal ? '0 : sfr_rd_data;
          end
        end
        SFR_ARB_ACK: begin
          state  <= SFR_ARB_IDLE;
          busy   <= 1'b0;
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          m0_err <= 1'b0;
          m1_err <= 1'b0;
        end
        default: begin
          state   <= SFR_ARB_IDLE;
          busy    <= 1'b0;
          sfr_we_ <= DISABLE_;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
